// File: rtl/jtag_dtm_pkg.sv
// Shared definitions for the JTAG DTM: IR codes, TAP states, DMI op/status codes.
// Optional feature macro: DEBUG__DTM_IDCODE_EN (IDCODE register present when defined).
// Pure declarations; no timing or flow control lives here.
package jtag_dtm_pkg;

  // Instruction register codes (5-bit IR)
  localparam logic [4:0] DEBUG__DTM_IR_IDCODE = 5'h01;
  localparam logic [4:0] DEBUG__DTM_IR_DTMCS  = 5'h10;
  localparam logic [4:0] DEBUG__DTM_IR_DMI    = 5'h11;
  localparam logic [4:0] DEBUG__DTM_IR_BYPASS = 5'h1f;

  // IEEE 1149.1 TAP controller states
  typedef enum logic [3:0] {
    TAP_TLR,
    TAP_RTI,
    TAP_SEL_DR,
    TAP_CAP_DR,
    TAP_SHIFT_DR,
    TAP_EXIT1_DR,
    TAP_PAUSE_DR,
    TAP_EXIT2_DR,
    TAP_UPD_DR,
    TAP_SEL_IR,
    TAP_CAP_IR,
    TAP_SHIFT_IR,
    TAP_EXIT1_IR,
    TAP_PAUSE_IR,
    TAP_EXIT2_IR,
    TAP_UPD_IR
  } tap_state_e;

  // DMI scan op field
  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;
  localparam logic [1:0] DMI_OP_RSVD  = 2'd3;

  // Sticky DMI status
  localparam logic [1:0] DMISTAT_OK     = 2'd0;
  localparam logic [1:0] DMISTAT_FAILED = 2'd2;
  localparam logic [1:0] DMISTAT_BUSY   = 2'd3;

  // DTMCS write-side control bits
  localparam int DTMCS_DMIRESET     = 16;
  localparam int DTMCS_DTMHARDRESET = 17;

  // Data register selected by the current instruction
  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_DTMCS,
    SEL_DMI
  } dr_sel_e;

  // Map an instruction to its data register; unknown codes fall back to BYPASS.
  function automatic dr_sel_e decode_ir(input logic [4:0] ir);
    dr_sel_e sel;
    case (ir)
`ifdef DEBUG__DTM_IDCODE_EN
      DEBUG__DTM_IR_IDCODE: sel = SEL_IDCODE;
`else
      DEBUG__DTM_IR_IDCODE: sel = SEL_BYPASS;
`endif
      DEBUG__DTM_IR_DTMCS:  sel = SEL_DTMCS;
      DEBUG__DTM_IR_DMI:    sel = SEL_DMI;
      default:              sel = SEL_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_dtm_if.sv
// Debug Module Interface: single-cycle read/write strobes with a shared data bus.
// Zero latency (pure wiring); the bus is resolved here from two tristate drivers.
// No backpressure: the DM must accept or answer a strobe in the cycle it appears.
interface dmi_if #(
  parameter int AddrWidth = 7
);
  logic [AddrWidth-1:0] address;
  logic                 read;
  logic                 write;
  logic [31:0]          wdata;     // initiator write data, on the bus only while write=1
  logic [31:0]          rdata;     // target read data
  logic                 rdata_oe;  // target drives the bus
  wire  [31:0]          data;

  // Both sides share one bus; whoever is not enabled floats it.
  assign data = write    ? wdata : 'z;
  assign data = rdata_oe ? rdata : 'z;

  modport master (
    output address,
    output read,
    output write,
    output wdata,
    input  data
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  data,
    output rdata,
    output rdata_oe
  );
endinterface

// File: rtl/jtag_dtm_tap.sv
// TAP front end: 2-FF synchronizers on TCK/TMS/TDI, TCK edge detect, 16-state TAP FSM.
// Latency: a TCK edge is seen as a one-clk rise/fall strobe 3 clks after the pin moves.
// No backpressure; TCK high and low must each last at least 3 clk periods.
module jtag_tap
  import jtag_dtm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tck,
  input  logic       i_tms,
  input  logic       i_tdi,
  output tap_state_e o_state,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_tdi
);

  logic       r_tck_s1, r_tck_s2, r_tck_s3;
  logic       r_tms_s1, r_tms_s2;
  logic       r_tdi_s1, r_tdi_s2;
  tap_state_e r_state;
  tap_state_e w_state_next;
  logic       w_rise;

  // Bring the JTAG pins into the clk domain; third TCK stage only feeds edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tck_s1 <= 1'b0;
      r_tck_s2 <= 1'b0;
      r_tck_s3 <= 1'b0;
      r_tms_s1 <= 1'b0;
      r_tms_s2 <= 1'b0;
      r_tdi_s1 <= 1'b0;
      r_tdi_s2 <= 1'b0;
    end else begin
      r_tck_s1 <= i_tck;
      r_tck_s2 <= r_tck_s1;
      r_tck_s3 <= r_tck_s2;
      r_tms_s1 <= i_tms;
      r_tms_s2 <= r_tms_s1;
      r_tdi_s1 <= i_tdi;
      r_tdi_s2 <= r_tdi_s1;
    end
  end

  assign w_rise  = r_tck_s2 & ~r_tck_s3;
  assign o_rise  = w_rise;
  assign o_fall  = ~r_tck_s2 & r_tck_s3;
  assign o_tdi   = r_tdi_s2;
  assign o_state = r_state;

  // TAP state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TAP_TLR;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Standard TAP transitions, taken only on a TCK rise.
  always_comb begin
    w_state_next = r_state;
    if (w_rise) begin
      case (r_state)
        TAP_TLR:      w_state_next = r_tms_s2 ? TAP_TLR      : TAP_RTI;
        TAP_RTI:      w_state_next = r_tms_s2 ? TAP_SEL_DR   : TAP_RTI;
        TAP_SEL_DR:   w_state_next = r_tms_s2 ? TAP_SEL_IR   : TAP_CAP_DR;
        TAP_CAP_DR:   w_state_next = r_tms_s2 ? TAP_EXIT1_DR : TAP_SHIFT_DR;
        TAP_SHIFT_DR: w_state_next = r_tms_s2 ? TAP_EXIT1_DR : TAP_SHIFT_DR;
        TAP_EXIT1_DR: w_state_next = r_tms_s2 ? TAP_UPD_DR   : TAP_PAUSE_DR;
        TAP_PAUSE_DR: w_state_next = r_tms_s2 ? TAP_EXIT2_DR : TAP_PAUSE_DR;
        TAP_EXIT2_DR: w_state_next = r_tms_s2 ? TAP_UPD_DR   : TAP_SHIFT_DR;
        TAP_UPD_DR:   w_state_next = r_tms_s2 ? TAP_SEL_DR   : TAP_RTI;
        TAP_SEL_IR:   w_state_next = r_tms_s2 ? TAP_TLR      : TAP_CAP_IR;
        TAP_CAP_IR:   w_state_next = r_tms_s2 ? TAP_EXIT1_IR : TAP_SHIFT_IR;
        TAP_SHIFT_IR: w_state_next = r_tms_s2 ? TAP_EXIT1_IR : TAP_SHIFT_IR;
        TAP_EXIT1_IR: w_state_next = r_tms_s2 ? TAP_UPD_IR   : TAP_PAUSE_IR;
        TAP_PAUSE_IR: w_state_next = r_tms_s2 ? TAP_EXIT2_IR : TAP_PAUSE_IR;
        TAP_EXIT2_IR: w_state_next = r_tms_s2 ? TAP_UPD_IR   : TAP_SHIFT_IR;
        TAP_UPD_IR:   w_state_next = r_tms_s2 ? TAP_SEL_DR   : TAP_RTI;
        default:      w_state_next = TAP_TLR;
      endcase
    end
  end

endmodule

// File: rtl/jtag_dtm.sv
// RISC-V 0.13 JTAG DTM: IR/DR scan chains (IDCODE, DTMCS, DMI, BYPASS) and DMI initiator.
// Latency: a DMI read/write strobe appears for one clk on the clk after the Update-DR TCK fall.
// No backpressure on DMI; BUSY is reported if a capture sees an unissued request. Macro: DEBUG__DTM_IDCODE_EN.
module jtag_dtm
  import jtag_dtm_pkg::*;
#(
  parameter int          AddrWidth = 7,
  parameter logic [31:0] IdCode    = 32'h00000001
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  tck,
  input  logic  tms,
  input  logic  tdi,
  output logic  tdo,
  dmi_if.master dmi
);

  localparam int DmiLen = AddrWidth + 34;
  localparam int ShLen  = (DmiLen > 32) ? DmiLen : 32;

  tap_state_e           w_tap_state;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_tdi;

  logic [4:0]           r_ir;
  logic [ShLen-1:0]     r_shreg;
  logic                 r_tdo;
  logic [1:0]           r_dmistat;
  logic [31:0]          r_result;
  logic [AddrWidth-1:0] r_last_addr;
  logic [31:0]          r_wdata;
  logic                 r_read;
  logic                 r_write;

  dr_sel_e              w_sel;
  int                   w_len;
  logic [ShLen-1:0]     w_shifted;
  logic [ShLen-1:0]     w_shift_next;
  logic [ShLen-1:0]     w_capture;
  logic [31:0]          w_dtmcs;
  logic [DmiLen-1:0]    w_dmi_cap;
  logic                 w_pending;
  logic                 w_in_shift;
  logic                 w_upd_dr;
  logic                 w_cap_dmi;
  logic [1:0]           w_upd_op;
  logic [31:0]          w_upd_data;
  logic [AddrWidth-1:0] w_upd_addr;

  jtag_tap u_tap (
    .clk     (clk),
    .rst     (rst),
    .i_tck   (tck),
    .i_tms   (tms),
    .i_tdi   (tdi),
    .o_state (w_tap_state),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_tdi   (w_tdi)
  );

  assign w_sel      = decode_ir(r_ir);
  assign w_in_shift = (w_tap_state == TAP_SHIFT_DR) || (w_tap_state == TAP_SHIFT_IR);
  assign w_upd_dr   = w_fall && (w_tap_state == TAP_UPD_DR);
  assign w_cap_dmi  = w_rise && (w_tap_state == TAP_CAP_DR) && (w_sel == SEL_DMI);
  // A request is outstanding exactly while its strobe is on the bus.
  assign w_pending  = r_read | r_write;

  assign w_upd_op   = r_shreg[1:0];
  assign w_upd_data = r_shreg[33:2];
  assign w_upd_addr = r_shreg[DmiLen-1:34];

  assign w_dtmcs   = {14'd0, 1'b0, 1'b0, 1'b0, 3'd1, r_dmistat, 6'(AddrWidth), 4'd1};
  assign w_dmi_cap = {r_last_addr, r_result, (w_pending ? DMISTAT_BUSY : r_dmistat)};

  // Length of the register currently being shifted; tdi enters at its MSB.
  always_comb begin
    w_len = 1;
    if (w_tap_state == TAP_SHIFT_IR) begin
      w_len = 5;
    end else begin
      case (w_sel)
        SEL_IDCODE: w_len = 32;
        SEL_DTMCS:  w_len = 32;
        SEL_DMI:    w_len = DmiLen;
        default:    w_len = 1;
      endcase
    end
  end

  // Right-shift by one within the active length; bits above it are kept clear.
  always_comb begin
    w_shifted    = {1'b0, r_shreg[ShLen-1:1]};
    w_shift_next = '0;
    for (int i = 0; i < ShLen; i++) begin
      if (i == w_len - 1) begin
        w_shift_next[i] = w_tdi;
      end else if (i < w_len - 1) begin
        w_shift_next[i] = w_shifted[i];
      end
    end
  end

  // Value parallel-loaded into the scan register in Capture-DR.
  always_comb begin
    w_capture = '0;
    case (w_sel)
`ifdef DEBUG__DTM_IDCODE_EN
      SEL_IDCODE: w_capture = ShLen'(IdCode);
`endif
      SEL_DTMCS:  w_capture = ShLen'(w_dtmcs);
      SEL_DMI:    w_capture = ShLen'(w_dmi_cap);
      default:    w_capture = '0;
    endcase
  end

  // Shared IR/DR scan register: capture and shift both happen on the TCK rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (w_rise) begin
      if (w_tap_state == TAP_CAP_IR) begin
        r_shreg <= ShLen'(5'b00001);
      end else if (w_tap_state == TAP_CAP_DR) begin
        r_shreg <= w_capture;
      end else if (w_in_shift) begin
        r_shreg <= w_shift_next;
      end
    end
  end

  // Instruction register: forced to IDCODE in Test-Logic-Reset, loaded on the Update-IR fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir <= DEBUG__DTM_IR_IDCODE;
    end else if (w_tap_state == TAP_TLR) begin
      r_ir <= DEBUG__DTM_IR_IDCODE;
    end else if (w_fall && (w_tap_state == TAP_UPD_IR)) begin
      r_ir <= r_shreg[4:0];
    end
  end

  // TDO changes on the TCK fall, so the host samples a stable bit on the next rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdo <= 1'b0;
    end else if (w_fall) begin
      r_tdo <= w_in_shift ? r_shreg[0] : 1'b0;
    end
  end

  // DMI request issue, read-data return and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_last_addr <= '0;
      r_result    <= '0;
      r_dmistat   <= DMISTAT_OK;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      r_read  <= 1'b0;
      r_write <= 1'b0;

      if (r_read) begin
        r_result <= dmi.data;
      end

      if (w_cap_dmi && w_pending) begin
        r_dmistat <= DMISTAT_BUSY;
      end

      if (w_upd_dr && (w_sel == SEL_DTMCS)) begin
        if (r_shreg[DTMCS_DTMHARDRESET]) begin
          // Hard reset also drops anything still outstanding.
          r_dmistat <= DMISTAT_OK;
          r_read    <= 1'b0;
          r_write   <= 1'b0;
        end else if (r_shreg[DTMCS_DMIRESET]) begin
          r_dmistat <= DMISTAT_OK;
        end
      end

      // Any non-zero status makes further ops no-ops until cleared through DTMCS.
      if (w_upd_dr && (w_sel == SEL_DMI) && (r_dmistat == DMISTAT_OK)) begin
        case (w_upd_op)
          DMI_OP_READ: begin
            r_read      <= 1'b1;
            r_last_addr <= w_upd_addr;
          end
          DMI_OP_WRITE: begin
            r_write     <= 1'b1;
            r_wdata     <= w_upd_data;
            r_last_addr <= w_upd_addr;
          end
          DMI_OP_RSVD: begin
            r_dmistat <= DMISTAT_FAILED;
          end
          default: ;
        endcase
      end
    end
  end

  assign tdo         = r_tdo;
  assign dmi.address = r_last_addr;
  assign dmi.read    = r_read;
  assign dmi.write   = r_write;
  assign dmi.wdata   = r_wdata;

endmodule
